// File: rtl/nios_print_fifo.sv
// Avalon-MM print-word decoder for Nios II debug output: per-channel escape decode into a FWFT record FIFO.
// Optional build macro PRINT_OVERFLOW_DROP_EN: drop records on a full FIFO instead of stalling the bus.
module nios_print_fifo #(
    parameter int CH_W       = 2,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              avs_chipselect,
    input  logic [CH_W:0]     avs_address,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic              avs_read,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [1:0]        rec_type,
    output logic [CH_W-1:0]   rec_channel,
    output logic [DATA_W-1:0] rec_data,
    output logic              stop_req,
    output logic [DATA_W-1:0] cycle_count
);

    localparam int NUM_CH = 2**CH_W;
    localparam int AW     = $clog2(FIFO_DEPTH);

    localparam logic [DATA_W-1:0] ESC_STOP = '1;
    localparam logic [DATA_W-1:0] ESC_FLT  = {{(DATA_W-2){1'b1}}, 2'b10};
    localparam logic [DATA_W-1:0] ESC_DEC  = {{(DATA_W-2){1'b1}}, 2'b01};
    localparam logic [DATA_W-1:0] ESC_CYC  = {{(DATA_W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {IDLE, EXP_FLT, EXP_DEC} dec_state_e;
    typedef enum logic [1:0] {REC_CHAR, REC_FLOAT, REC_DEC, REC_CYCLES} rec_type_e;

    dec_state_e state_q [NUM_CH];
    dec_state_e state_d [NUM_CH];

    logic              sel_ctrl;
    logic [CH_W-1:0]   ch;
    logic              wr_acc;
    logic              data_wr;
    logic              ctrl_wr;

    logic              push;
    rec_type_e         push_type;
    logic [DATA_W-1:0] push_data;
    logic              stop_set;

    logic [1:0]        mem_type [FIFO_DEPTH];
    logic [CH_W-1:0]   mem_ch   [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              do_push;
    logic              do_pop;
    logic              overflow_q;
    logic [DATA_W-1:0] status;

    assign sel_ctrl = avs_address[CH_W];
    assign ch       = avs_address[CH_W-1:0];
    assign wr_acc   = avs_chipselect & avs_write & ~avs_waitrequest;
    assign data_wr  = wr_acc & ~sel_ctrl;
    assign ctrl_wr  = wr_acc & sel_ctrl;

    assign full = (count == (AW+1)'(FIFO_DEPTH));

`ifdef PRINT_OVERFLOW_DROP_EN
    assign avs_waitrequest = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow_q <= 1'b0;
        else if (push & full)
            overflow_q <= 1'b1;
        else if (ctrl_wr & avs_writedata[2])
            overflow_q <= 1'b0;
    end
`else
    assign avs_waitrequest = avs_chipselect & avs_write & ~sel_ctrl & full;
    assign overflow_q      = 1'b0;
`endif

    // Only the addressed channel can change state in a given cycle.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_type = REC_CHAR;
        push_data = '0;
        stop_set  = 1'b0;
        if (data_wr) begin
            case (state_q[ch])
                IDLE: begin
                    if (avs_writedata == ESC_STOP) begin
                        stop_set = 1'b1;
                    end else if (avs_writedata == ESC_FLT) begin
                        state_d[ch] = EXP_FLT;
                    end else if (avs_writedata == ESC_DEC) begin
                        state_d[ch] = EXP_DEC;
                    end else if (avs_writedata == ESC_CYC) begin
                        push      = 1'b1;
                        push_type = REC_CYCLES;
                        push_data = cycle_count;
                    end else begin
                        push           = 1'b1;
                        push_type      = REC_CHAR;
                        push_data[7:0] = avs_writedata[7:0];
                    end
                end
                EXP_FLT: begin
                    push        = 1'b1;
                    push_type   = REC_FLOAT;
                    push_data   = avs_writedata;
                    state_d[ch] = IDLE;
                end
                EXP_DEC: begin
                    push        = 1'b1;
                    push_type   = REC_DEC;
                    push_data   = avs_writedata;
                    state_d[ch] = IDLE;
                end
                default: state_d[ch] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++)
                state_q[i] <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign do_push = push & ~full;
    assign do_pop  = rec_valid & rec_ready;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_type[wr_ptr] <= push_type;
            mem_ch[wr_ptr]   <= ch;
            mem_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push & ~do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop & ~do_push)
                count <= count - (AW+1)'(1);
        end
    end

    // Head fields are masked while empty so they read 0 out of reset without resetting the RAM.
    assign rec_valid   = (count != '0);
    assign rec_type    = rec_valid ? mem_type[rd_ptr] : '0;
    assign rec_channel = rec_valid ? mem_ch[rd_ptr]   : '0;
    assign rec_data    = rec_valid ? mem_data[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stop_req <= 1'b0;
        else if (stop_set)
            stop_req <= 1'b1;
        else if (ctrl_wr & avs_writedata[0])
            stop_req <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cycle_count <= '0;
        else if (ctrl_wr & avs_writedata[1])
            cycle_count <= '0;
        else
            cycle_count <= cycle_count + DATA_W'(1);
    end

    always_comb begin
        status           = '0;
        status[DATA_W-1] = stop_req;
        status[DATA_W-2] = full;
        status[DATA_W-3] = overflow_q;
        status[15:0]     = 16'(count);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            avs_readdata <= '0;
        else if (avs_chipselect & avs_read)
            avs_readdata <= sel_ctrl ? status : '0;
    end

endmodule

// File: tb/tb_nios_print_fifo.sv
// Directed bench for nios_print_fifo: vector table for single-word decode, hand sequences for
// backpressure, cycle snapshot, stop flag and reset.
module tb_nios_print_fifo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        avs_chipselect = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        rec_valid;
    logic        rec_ready = 1'b0;
    logic [1:0]  rec_type;
    logic [1:0]  rec_channel;
    logic [31:0] rec_data;
    logic        stop_req;
    logic [31:0] cycle_count;

    int total = 0;
    int bad   = 0;

    nios_print_fifo #(.CH_W(2), .DATA_W(32), .FIFO_DEPTH(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avs_chipselect (avs_chipselect),
        .avs_address    (avs_address),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .avs_waitrequest(avs_waitrequest),
        .rec_valid      (rec_valid),
        .rec_ready      (rec_ready),
        .rec_type       (rec_type),
        .rec_channel    (rec_channel),
        .rec_data       (rec_data),
        .stop_req       (stop_req),
        .cycle_count    (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] wd;
        logic        has;
        logic [1:0]  typ;
        logic [31:0] data;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        int  n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_address    = a;
        avs_writedata  = d;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = !avs_waitrequest;
            @(posedge clk);
            #1;
            n++;
        end
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL wr_timeout: got waitrequest=1 for 50 cycles expected accept addr=%0d", a);
        end
    endtask

    task automatic rd_status(output logic [31:0] v);
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_address    = 3'b100;
        @(posedge clk);
        #1;
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        v = avs_readdata;
    endtask

    task automatic pop_one();
        rec_ready = 1'b1;
        @(posedge clk);
        #1;
        rec_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [14];
        logic [31:0] st;

        vecs[0]  = '{2'd0, 32'h0000_0041, 1'b1, 2'd0, 32'h0000_0041};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFD, 1'b0, 2'd0, 32'h0};
        vecs[2]  = '{2'd1, 32'hFFFF_FFFF, 1'b1, 2'd2, 32'hFFFF_FFFF};
        vecs[3]  = '{2'd2, 32'hFFFF_FFFE, 1'b0, 2'd0, 32'h0};
        vecs[4]  = '{2'd3, 32'h0000_0042, 1'b1, 2'd0, 32'h0000_0042};
        vecs[5]  = '{2'd2, 32'h3F80_0000, 1'b1, 2'd1, 32'h3F80_0000};
        vecs[6]  = '{2'd3, 32'h1234_5678, 1'b1, 2'd0, 32'h0000_0078};
        vecs[7]  = '{2'd0, 32'hFFFF_FFFE, 1'b0, 2'd0, 32'h0};
        vecs[8]  = '{2'd1, 32'hFFFF_FFFE, 1'b0, 2'd0, 32'h0};
        vecs[9]  = '{2'd0, 32'hFFFF_FFFC, 1'b1, 2'd1, 32'hFFFF_FFFC};
        vecs[10] = '{2'd1, 32'hFFFF_FFFD, 1'b1, 2'd1, 32'hFFFF_FFFD};
        vecs[11] = '{2'd2, 32'hFFFF_FFFD, 1'b0, 2'd0, 32'h0};
        vecs[12] = '{2'd2, 32'hFFFF_FFFE, 1'b1, 2'd2, 32'hFFFF_FFFE};
        vecs[13] = '{2'd3, 32'h0000_00FF, 1'b1, 2'd0, 32'h0000_00FF};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", rec_valid, 0);
        chk("rst_type", rec_type, 0);
        chk("rst_channel", rec_channel, 0);
        chk("rst_data", rec_data, 0);
        chk("rst_stop", stop_req, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_readdata", avs_readdata, 0);
        chk("rst_waitreq", avs_waitrequest, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-word decode vectors; every record is popped before the next write
        for (int i = 0; i < 14; i++) begin
            wr({1'b0, vecs[i].ch}, vecs[i].wd);
            chk($sformatf("vec%0d_valid", i), rec_valid, vecs[i].has);
            if (vecs[i].has) begin
                chk($sformatf("vec%0d_type", i), rec_type, vecs[i].typ);
                chk($sformatf("vec%0d_ch", i), rec_channel, vecs[i].ch);
                chk($sformatf("vec%0d_data", i), rec_data, vecs[i].data);
                pop_one();
                chk($sformatf("vec%0d_popped", i), rec_valid, 0);
            end
        end
        chk("vec_stop_clear", stop_req, 0);

        // Fill the FIFO with rec_ready low, then one write beyond depth
        for (int i = 0; i < 16; i++)
            wr(3'b000, 32'h30 + i);
        rd_status(st);
        chk("full_status", st, 32'h4000_0010);
`ifdef PRINT_OVERFLOW_DROP_EN
        wr(3'b000, 32'h50);
        rd_status(st);
        chk("drop_status", st, 32'h6000_0010);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), rec_data, 32'h30 + i);
            pop_one();
        end
        chk("drain_empty", rec_valid, 0);
        wr(3'b100, 32'h4);
        rd_status(st);
        chk("ovf_cleared", st, 32'h0);
`else
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_address    = 3'b000;
        avs_writedata  = 32'h50;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("full_wait%0d", i), avs_waitrequest, 1);
            @(posedge clk);
            #1;
        end
        rec_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_wait", avs_waitrequest, 1);
        chk("full_head", rec_data, 32'h30);
        @(posedge clk);
        #1;
        rec_ready = 1'b0;
        @(negedge clk);
        chk("after_pop_wait", avs_waitrequest, 0);
        @(posedge clk);
        #1;
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
        rd_status(st);
        chk("refill_status", st, 32'h4000_0010);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), rec_data, (i == 15) ? 32'h50 : 32'h31 + i);
            pop_one();
        end
        chk("drain_empty", rec_valid, 0);
        rd_status(st);
        chk("empty_status", st, 32'h0);
`endif

        // Cycle snapshot, stop flag set and clear
        wr(3'b100, 32'h2);
        chk("cyc_zeroed", cycle_count, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("cyc_count5", cycle_count, 5);
        wr(3'b000, 32'hFFFF_FFFC);
        chk("cyc_valid", rec_valid, 1);
        chk("cyc_type", rec_type, 3);
        chk("cyc_ch", rec_channel, 0);
        chk("cyc_data", rec_data, 5);
        pop_one();
        wr(3'b000, 32'hFFFF_FFFF);
        chk("stop_set", stop_req, 1);
        chk("stop_norec", rec_valid, 0);
        rd_status(st);
        chk("stop_status", st, 32'h8000_0000);
        wr(3'b100, 32'h1);
        chk("stop_cleared", stop_req, 0);
        rd_status(st);
        chk("stop_status_clr", st, 32'h0);

        // Reset mid-run: queued records and partial escapes discarded
        for (int i = 0; i < 5; i++)
            wr(3'b010, 32'h60 + i);
        wr(3'b001, 32'hFFFF_FFFE);
        rd_status(st);
        chk("pre_rst_level", st, 32'h0000_0005);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", rec_valid, 0);
        chk("mid_rst_data", rec_data, 0);
        chk("mid_rst_cycle", cycle_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        rd_status(st);
        chk("post_rst_level", st, 32'h0);
        wr(3'b001, 32'h0000_0041);
        chk("post_rst_valid", rec_valid, 1);
        chk("post_rst_type", rec_type, 0);
        chk("post_rst_data", rec_data, 32'h41);
        pop_one();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
